bg_tile_serializer: RTL and testbench

BG_TILE_SERIALIZER -- requirements
Module: bg_tile_serializer

---
 rtl/bg_tile_serializer_pkg.sv | 23 ++
 rtl/bg_tile_serializer_shift8x2.sv | 56 +++++
 rtl/bg_tile_serializer.sv | 177 +++++++++++++++++
 tb/tb_bg_tile_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bg_tile_serializer_pkg.sv
// Shared definitions for the background tile serializer: fetch FSM encoding,
// ROM word field layout and the line-start detector.
package bg_tile_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam int FETCH_W  = 20;
    localparam int P0_LSB   = 0;
    localparam int P1_LSB   = 8;
    localparam int ATTR_LSB = 16;

    // A line starts on the pixel where the sampled hblank falls.
    function automatic logic line_start_f(input logic pix_ce,
                                          input logic hblank_prev,
                                          input logic hblank);
        return pix_ce & hblank_prev & ~hblank;
    endfunction

endpackage

// File: rtl/bg_tile_serializer_shift8x2.sv
// Two-plane 8-bit loadable shifter with attribute latch; the shift direction
// is captured together with each load.
module bg_shift8x2 (
    input  logic       clk1,
    input  logic       n_clr1,
    input  logic       clr,
    input  logic       load,
    input  logic       shift_en,
    input  logic       flip_in,
    input  logic [7:0] p0_in,
    input  logic [7:0] p1_in,
    input  logic [3:0] attr_in,
    output logic [1:0] pix,
    output logic [3:0] attr
);

    logic [7:0] p0_r;
    logic [7:0] p1_r;
    logic [3:0] attr_r;
    logic       flip_r;

    assign pix  = flip_r ? {p1_r[0], p0_r[0]} : {p1_r[7], p0_r[7]};
    assign attr = attr_r;

    // Plane/attr storage: clear, reload, or shift one pixel out.
    always_ff @(posedge clk1 or negedge n_clr1) begin
        if (!n_clr1) begin
            p0_r   <= 8'd0;
            p1_r   <= 8'd0;
            attr_r <= 4'd0;
            flip_r <= 1'b0;
        end else if (clr) begin
            p0_r   <= 8'd0;
            p1_r   <= 8'd0;
            attr_r <= 4'd0;
            flip_r <= 1'b0;
        end else if (load) begin
            p0_r   <= p0_in;
            p1_r   <= p1_in;
            attr_r <= attr_in;
            flip_r <= flip_in;
        end else if (shift_en) begin
            if (flip_r) begin
                p0_r <= {1'b0, p0_r[7:1]};
                p1_r <= {1'b0, p1_r[7:1]};
            end else begin
                p0_r <= {p0_r[6:0], 1'b0};
                p1_r <= {p1_r[6:0], 1'b0};
            end
        end else begin
            p0_r <= p0_r;
            p1_r <= p1_r;
        end
    end

endmodule

// File: rtl/bg_tile_serializer.sv
// Background tile serializer: fetches one tile row per column from ROM into a
// single buffer and shifts it out two bitplanes at a time, one pixel per pix_ce.
module bg_tile_serializer
    import bg_tile_serializer_pkg::*;
#(
    parameter int COLS = 32
) (
    input  logic                    clk1,
    input  logic                    n_clr1,
    input  logic                    pix_ce,
    input  logic                    hblank,
    input  logic                    ena_bg,
    input  logic                    flip,
    input  logic                    fetch_ack,
    input  logic [FETCH_W-1:0]      fetch_data,
    output logic                    fetch_req,
    output logic [$clog2(COLS)-1:0] fetch_col,
    output logic [5:0]              color,
    output logic                    opaque,
    output logic                    underrun
);

    localparam int CW = $clog2(COLS);

    fetch_state_e         state_r, state_s;
    logic [CW-1:0]        col_r;
    logic [FETCH_W-1:0]   buf_r;
    logic                 buf_vld_r;
    logic                 hblank_prev_r;
    logic                 line_act_r;
    logic                 discard_r;
    logic [2:0]           phase_r;
    logic                 fetch_req_r;
    logic [5:0]           color_r;
    logic                 opaque_r;
    logic                 underrun_r;

    logic                 line_start_s;
    logic                 active_pix_s;
    logic                 hb_pix_s;
    logic [2:0]           phase_cur_s;
    logic                 reload_s;
    logic                 take_s;
    logic                 ack_s;
    logic                 drop_s;
    logic                 capture_s;
    logic [1:0]           shf_pix_s;
    logic [3:0]           shf_attr_s;

    assign line_start_s = line_start_f(pix_ce, hblank_prev_r, hblank);
    assign active_pix_s = pix_ce & ~hblank;
    assign hb_pix_s     = pix_ce & hblank;
    // The line-start pixel itself counts as phase 0.
    assign phase_cur_s  = line_start_s ? 3'd0 : phase_r;
    assign reload_s     = active_pix_s & (phase_cur_s == 3'd7);
    assign take_s       = reload_s & buf_vld_r;
    assign ack_s        = fetch_ack & (state_r == ST_REQ);
    assign drop_s       = discard_r | hb_pix_s;
    assign capture_s    = ack_s & ~drop_s & ~line_start_s;

    assign fetch_req = fetch_req_r;
    assign fetch_col = col_r;
    assign color     = color_r;
    assign opaque    = opaque_r;
    assign underrun  = underrun_r;

    // Fetch FSM next-state.
    always_comb begin
        state_s = state_r;
        if (line_start_s) begin
            state_s = ST_REQ;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!buf_vld_r && line_act_r && !hblank) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        state_s = drop_s ? ST_IDLE : ST_HOLD;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (take_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Fetch state, column, buffer and line tracking.
    always_ff @(posedge clk1 or negedge n_clr1) begin
        if (!n_clr1) begin
            state_r       <= ST_IDLE;
            fetch_req_r   <= 1'b0;
            col_r         <= '0;
            buf_r         <= '0;
            buf_vld_r     <= 1'b0;
            hblank_prev_r <= 1'b0;
            line_act_r    <= 1'b0;
            discard_r     <= 1'b0;
            phase_r       <= 3'd0;
        end else begin
            state_r     <= state_s;
            fetch_req_r <= (state_s == ST_REQ);
            if (pix_ce) hblank_prev_r <= hblank;

            if (line_start_s)  line_act_r <= 1'b1;
            else if (hb_pix_s) line_act_r <= 1'b0;

            if (line_start_s)   col_r <= '0;
            else if (capture_s) col_r <= col_r + CW'(1);

            // A take in the capture cycle consumes the old word first.
            if (line_start_s) begin
                buf_r     <= '0;
                buf_vld_r <= 1'b0;
            end else if (capture_s) begin
                buf_r     <= fetch_data;
                buf_vld_r <= 1'b1;
            end else if (take_s) begin
                buf_vld_r <= 1'b0;
            end

            if (line_start_s || state_s != ST_REQ) discard_r <= 1'b0;
            else if (hb_pix_s)                     discard_r <= 1'b1;

            if (active_pix_s) phase_r <= phase_cur_s + 3'd1;
        end
    end

    // Registered pixel output and sticky underrun flag.
    always_ff @(posedge clk1 or negedge n_clr1) begin
        if (!n_clr1) begin
            color_r    <= 6'd0;
            opaque_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (line_start_s)                underrun_r <= 1'b1 & 1'b0;
            else if (reload_s && !buf_vld_r) underrun_r <= 1'b1;

            if (pix_ce) begin
                if (line_start_s || hblank || !ena_bg) begin
                    color_r  <= 6'd0;
                    opaque_r <= 1'b0;
                end else begin
                    color_r  <= {shf_attr_s, shf_pix_s};
                    opaque_r <= |shf_pix_s;
                end
            end
        end
    end

    bg_shift8x2 u_shift (
        .clk1     (clk1),
        .n_clr1   (n_clr1),
        .clr      (line_start_s),
        .load     (reload_s),
        .shift_en (active_pix_s),
        .flip_in  (flip),
        .p0_in    (take_s ? buf_r[P0_LSB +: 8]   : 8'd0),
        .p1_in    (take_s ? buf_r[P1_LSB +: 8]   : 8'd0),
        .attr_in  (take_s ? buf_r[ATTR_LSB +: 4] : 4'd0),
        .pix      (shf_pix_s),
        .attr     (shf_attr_s)
    );

endmodule

// File: tb/tb_bg_tile_serializer.sv
// Scoreboard bench for bg_tile_serializer with a 2-cycle-latency ROM responder.
module tb_bg_tile_serializer;

    localparam int COLS = 32;

    logic        clk1 = 1'b0;
    logic        n_clr1 = 1'b0;
    logic        pix_ce = 1'b0;
    logic        hblank = 1'b1;
    logic        ena_bg = 1'b1;
    logic        flip = 1'b0;
    logic        fetch_ack = 1'b0;
    logic [19:0] fetch_data = 20'd0;
    logic        fetch_req;
    logic [4:0]  fetch_col;
    logic [5:0]  color;
    logic        opaque;
    logic        underrun;

    logic        rom_en = 1'b0;
    logic [19:0] rom_word = 20'd0;
    logic        stray_ack_en = 1'b0;
    logic [4:0]  col_q[$];

    typedef struct {
        logic [5:0] color;
        logic       opaque;
        bit         chk_c;
        bit         chk_o;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    bg_tile_serializer #(.COLS(COLS)) dut (
        .clk1       (clk1),
        .n_clr1     (n_clr1),
        .pix_ce     (pix_ce),
        .hblank     (hblank),
        .ena_bg     (ena_bg),
        .flip       (flip),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .fetch_req  (fetch_req),
        .fetch_col  (fetch_col),
        .color      (color),
        .opaque     (opaque),
        .underrun   (underrun)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_color(input logic [3:0] a, input logic [7:0] p1,
                                             input logic [7:0] p0, input bit flp, input int k);
        int b;
        b = flp ? k : 7 - k;
        return {a, p1[b], p0[b]};
    endfunction

    // ROM model: acks two cycles after it sees a request, records the column.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk1);
            #2;
            fetch_ack = stray_ack_en;
            if (fetch_req && rom_en) begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    fetch_ack  = 1'b1;
                    fetch_data = rom_word;
                    col_q.push_back(fetch_col);
                    wait_cnt   = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic pixel(input string tag, input bit chk_c, input logic [5:0] ec,
                         input bit chk_o, input logic eo);
        exp_t e;
        exp_q.push_back('{color: ec, opaque: eo, chk_c: chk_c, chk_o: chk_o});
        @(posedge clk1); #1; pix_ce = 1'b1;
        @(posedge clk1); #1; pix_ce = 1'b0;
        e = exp_q.pop_front();
        if (e.chk_c) check({tag, "_color"}, 32'(color), 32'(e.color));
        if (e.chk_o) check({tag, "_opaque"}, 32'(opaque), 32'(e.opaque));
        repeat (2) @(posedge clk1);
    endtask

    task automatic start_line();
        hblank = 1'b1;
        pixel("hblank", 1'b1, 6'd0, 1'b1, 1'b0);
        hblank = 1'b0;
    endtask

    task automatic end_line();
        hblank = 1'b1;
        pixel("hblank", 1'b1, 6'd0, 1'b1, 1'b0);
    endtask

    task automatic tile_line(input string tag, input logic [3:0] a, input logic [7:0] p1,
                             input logic [7:0] p0, input bit flp, input logic [15:0] ena_off);
        logic [5:0] c;
        rom_en   = 1'b1;
        rom_word = {a, p1, p0};
        flip     = flp;
        start_line();
        for (int i = 0; i < 16; i++) begin
            ena_bg = ~ena_off[i];
            if (i < 8) begin
                pixel($sformatf("%s_px%0d", tag, i), 1'b0, 6'd0, 1'b1, 1'b0);
            end else if (ena_off[i]) begin
                pixel($sformatf("%s_px%0d", tag, i), 1'b1, 6'd0, 1'b1, 1'b0);
            end else begin
                c = exp_color(a, p1, p0, flp, i - 8);
                pixel($sformatf("%s_px%0d", tag, i), 1'b1, c, 1'b1, |c[1:0]);
            end
            if (i == 0) check({tag, "_underrun_clr"}, 32'(underrun), 32'd0);
        end
        ena_bg = 1'b1;
        end_line();
    endtask

    initial begin
        int base;
        logic [5:0] c;

        // Reset state.
        #1;
        check("rst_req", 32'(fetch_req), 32'd0);
        check("rst_col", 32'(fetch_col), 32'd0);
        check("rst_color", 32'(color), 32'd0);
        check("rst_opaque", 32'(opaque), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        repeat (2) @(posedge clk1);
        #1; n_clr1 = 1'b1;

        tile_line("flip0", 4'h5, 8'h00, 8'h80, 1'b0, 16'h0000);
        tile_line("flip1", 4'h5, 8'h00, 8'h80, 1'b1, 16'h0000);

        // No ack for 20 pixels: underruns, then data at the next reload.
        rom_en   = 1'b0;
        rom_word = {4'h5, 8'h00, 8'h80};
        flip     = 1'b0;
        start_line();
        for (int i = 0; i < 32; i++) begin
            if (i == 20) rom_en = 1'b1;
            if (i < 8) begin
                pixel($sformatf("undr_px%0d", i), 1'b0, 6'd0, 1'b1, 1'b0);
            end else if (i < 24) begin
                pixel($sformatf("undr_px%0d", i), 1'b1, 6'd0, 1'b1, 1'b0);
            end else begin
                c = exp_color(4'h5, 8'h00, 8'h80, 1'b0, i - 24);
                pixel($sformatf("undr_px%0d", i), 1'b1, c, 1'b1, |c[1:0]);
            end
            if (i == 6) check("undr_before_reload", 32'(underrun), 32'd0);
            if (i == 7) check("undr_at_reload", 32'(underrun), 32'd1);
        end
        check("undr_sticky", 32'(underrun), 32'd1);
        end_line();
        tile_line("after_undr", 4'h5, 8'h00, 8'h80, 1'b0, 16'h0000);

        // Column sequence across 33 fetches.
        rom_en = 1'b1;
        base   = col_q.size();
        start_line();
        for (int i = 0; i < 270; i++) pixel("colseq", 1'b0, 6'd0, 1'b0, 1'b0);
        end_line();
        check("colseq_count_ok", 32'(col_q.size() >= base + 33), 32'd1);
        for (int i = 0; i < 33; i++) begin
            if (base + i < col_q.size())
                check($sformatf("colseq_%0d", i), 32'(col_q[base + i]), 32'(i % COLS));
        end

        // hblank rises while a request is outstanding: ack is dropped.
        rom_en = 1'b0;
        base   = col_q.size();
        start_line();
        pixel("disc_px0", 1'b1, 6'd0, 1'b1, 1'b0);
        end_line();
        rom_en = 1'b1;
        repeat (8) @(posedge clk1);
        #1;
        check("disc_acked", 32'(col_q.size()), 32'(base + 1));
        check("disc_col", 32'(fetch_col), 32'd0);
        check("disc_req", 32'(fetch_req), 32'd0);

        tile_line("ena", 4'h5, 8'h00, 8'h24, 1'b0, 16'h1C00);

        // Reset during an outstanding request.
        rom_en = 1'b0;
        start_line();
        for (int i = 0; i < 9; i++) pixel("rst_line", 1'b0, 6'd0, 1'b0, 1'b0);
        check("mid_pre_req", 32'(fetch_req), 32'd1);
        check("mid_pre_underrun", 32'(underrun), 32'd1);
        @(posedge clk1); #1;
        n_clr1 = 1'b0;
        #1;
        check("mid_req", 32'(fetch_req), 32'd0);
        check("mid_col", 32'(fetch_col), 32'd0);
        check("mid_color", 32'(color), 32'd0);
        check("mid_opaque", 32'(opaque), 32'd0);
        check("mid_underrun", 32'(underrun), 32'd0);
        repeat (2) @(posedge clk1);
        #1; n_clr1 = 1'b1;
        @(posedge clk1); #1; stray_ack_en = 1'b1;
        @(posedge clk1); #1; stray_ack_en = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        check("stray_req", 32'(fetch_req), 32'd0);
        check("stray_col", 32'(fetch_col), 32'd0);
        for (int i = 0; i < 3; i++) pixel("post_rst", 1'b1, 6'd0, 1'b1, 1'b0);
        check("post_rst_idle", 32'(fetch_req), 32'd0);
        base = col_q.size();
        tile_line("resume", 4'h5, 8'h00, 8'h80, 1'b0, 16'h0000);
        check("resume_col0", 32'(col_q.size() > base ? col_q[base] : 5'd31), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
